stream_demux4: RTL and testbench

Four-way demultiplexer for a valid/ready packet stream: one input stream is steered to one of four output channels chosen by a 2-bit select. The select is sampled on the first beat of each packet and held until its last beat, so packets are never split across channels. A single registered output stage isolates input timing from the outputs. This is the distribution-side counterpart of the 4:1 select muxes used elsewhere in the datapath, placed where one producer feeds four consumers.

---
 rtl/stream_demux4_pkg.sv | 10 +
 rtl/stream_demux4_if.sv | 23 ++
 rtl/stream_demux4_onehot_decoder2.sv | 11 +
 rtl/stream_demux4.sv | 70 +++++++
 tb/tb_stream_demux4.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/stream_demux4_pkg.sv
// Shared types and constants for the 4-way packet stream demultiplexer.
package stream_demux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/stream_demux4_if.sv
// Stream bus of the demux: one producer side, four consumer channels sharing data/last.
interface stream_demux4_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0]                        data_in;
  logic                                    valid_in;
  logic                                    last_in;
  logic [stream_demux4_pkg::SEL_W-1:0]     sel_in;
  logic                                    ready_out;
  logic [WIDTH-1:0]                        data_out;
  logic                                    last_out;
  logic [stream_demux4_pkg::NUM_CH-1:0]    valid_out;
  logic [stream_demux4_pkg::NUM_CH-1:0]    ready_in;
  logic                                    busy_out;

  modport slave (
    input  data_in, valid_in, last_in, sel_in, ready_in,
    output ready_out, data_out, last_out, valid_out, busy_out
  );

  modport master (
    output data_in, valid_in, last_in, sel_in, ready_in,
    input  ready_out, data_out, last_out, valid_out, busy_out
  );
endinterface

// File: rtl/stream_demux4_onehot_decoder2.sv
// 2-bit channel index to 4-bit one-hot.
module onehot_decoder2
  import stream_demux4_pkg::*;
(
  input  logic [SEL_W-1:0]  i_idx,
  output logic [NUM_CH-1:0] o_onehot
);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_bit
    assign o_onehot[n] = (i_idx == SEL_W'(n));
  end
endmodule

// File: rtl/stream_demux4.sv
// 1:4 packet demux with a single registered output stage; the channel is locked
// on a packet's first beat so a packet never splits across consumers.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  stream_demux4_if.slave bus
);
  logic               r_occ;
  logic [WIDTH-1:0]   r_data;
  logic               r_last;
  logic [SEL_W-1:0]   r_dst;
  logic [SEL_W-1:0]   r_cur_sel;
  state_t             r_state;

  logic [NUM_CH-1:0]  w_dst_oh;
  logic               w_pop;
  logic               w_ready;
  logic               w_accept;
  logic [SEL_W-1:0]   w_route;

  onehot_decoder2 u_dec (
    .i_idx    (r_dst),
    .o_onehot (w_dst_oh)
  );

  // Only the ready of the channel holding the registered beat can drain it.
  assign w_pop    = r_occ & (|(w_dst_oh & bus.ready_in));
  assign w_ready  = ~r_occ | w_pop;
  assign w_accept = bus.valid_in & w_ready;
  assign w_route  = (r_state == BUSY) ? r_cur_sel : bus.sel_in;

  assign bus.ready_out = w_ready;
  assign bus.valid_out = r_occ ? w_dst_oh : '0;
  assign bus.data_out  = r_data;
  assign bus.last_out  = r_last;
  assign bus.busy_out  = (r_state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ     <= 1'b0;
      r_data    <= '0;
      r_last    <= 1'b0;
      r_dst     <= '0;
      r_cur_sel <= '0;
      r_state   <= IDLE;
    end else begin
      if (w_accept) begin
        r_data <= bus.data_in;
        r_last <= bus.last_in;
        r_dst  <= w_route;
        r_occ  <= 1'b1;
      end else if (w_pop) begin
        r_occ  <= 1'b0;
      end

      case (r_state)
        IDLE: if (w_accept && !bus.last_in) begin
          r_cur_sel <= bus.sel_in;
          r_state   <= BUSY;
        end
        BUSY: if (w_accept && bus.last_in) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: directed scenarios then random traffic, all checked
// against a packet-level scoreboard of expected output beats.
module tb_stream_demux4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux4_if #(.WIDTH(8)) bus ();

  stream_demux4 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         ch;
  } beat_t;

  beat_t q[$];          // beats accepted but not yet consumed
  bit    m_in_pkt = 0;  // a packet has started and its last beat not yet accepted
  int    m_ch     = 0;  // channel locked for the current packet

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                       input logic l, input logic [3:0] r);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.sel_in   = s;
    bus.last_in  = l;
    bus.ready_in = r;
  endtask

  // Check outputs mid-cycle, then advance the scoreboard across the next edge.
  task automatic tick();
    logic  exp_rdy;
    logic  acc;
    beat_t b;
    @(negedge clk);
    exp_rdy = (q.size() == 0) || bus.ready_in[q[0].ch];
    chk("ready_out", 32'(bus.ready_out), 32'(exp_rdy));
    chk("busy_out", 32'(bus.busy_out), 32'(m_in_pkt));
    if (q.size() == 0) begin
      chk("valid_out_idle", 32'(bus.valid_out), 32'd0);
    end else begin
      chk("valid_out", 32'(bus.valid_out), 32'(1) << q[0].ch);
      chk("data_out", 32'(bus.data_out), 32'(q[0].d));
      chk("last_out", 32'(bus.last_out), 32'(q[0].l));
    end
    acc = bus.valid_in && exp_rdy;
    if (q.size() != 0 && bus.ready_in[q[0].ch]) void'(q.pop_front());
    if (acc) begin
      b.d  = bus.data_in;
      b.l  = bus.last_in;
      b.ch = m_in_pkt ? m_ch : int'(bus.sel_in);
      q.push_back(b);
      if (!m_in_pkt && !bus.last_in) begin
        m_in_pkt = 1;
        m_ch     = int'(bus.sel_in);
      end else if (m_in_pkt && bus.last_in) begin
        m_in_pkt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    bus.valid_in = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_in_pkt = 0;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_busy_out", 32'(bus.busy_out), 32'd0);
    chk("rst_ready_out", 32'(bus.ready_out), 32'd1);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    chk("rst_last_out", 32'(bus.last_out), 32'd0);
  endtask

  initial begin
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    do_rst();

    // single-beat packet to ch2
    drive(1'b1, 8'hA5, 2'd2, 1'b1, 4'hF);
    tick();
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    chk("t1_valid", 32'(bus.valid_out), 32'h4);
    chk("t1_data", 32'(bus.data_out), 32'hA5);
    chk("t1_last", 32'(bus.last_out), 32'd1);
    chk("t1_busy", 32'(bus.busy_out), 32'd0);
    tick();

    // 3-beat packet: select changes after beat 1 must be ignored
    drive(1'b1, 8'h01, 2'd1, 1'b0, 4'hF); tick();
    chk("t2_busy_mid", 32'(bus.busy_out), 32'd1);
    drive(1'b1, 8'h02, 2'd3, 1'b0, 4'hF); tick();
    drive(1'b1, 8'h03, 2'd3, 1'b1, 4'hF); tick();
    chk("t2_busy_end", 32'(bus.busy_out), 32'd0);
    chk("t2_valid_last", 32'(bus.valid_out), 32'h2);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF); tick();

    // output stall on ch0 for 5 cycles, then release
    drive(1'b1, 8'h10, 2'd0, 1'b1, 4'hE); tick();
    drive(1'b1, 8'h11, 2'd1, 1'b1, 4'hE);
    repeat (5) tick();
    chk("t3_stall_data", 32'(bus.data_out), 32'h10);
    bus.ready_in = 4'hF; tick();
    chk("t3_next_valid", 32'(bus.valid_out), 32'h2);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF); tick();

    // back-to-back: 2 beats to ch0, 1 beat to ch3
    drive(1'b1, 8'h20, 2'd0, 1'b0, 4'hF); tick();
    drive(1'b1, 8'h21, 2'd2, 1'b1, 4'hF); tick();
    drive(1'b1, 8'h22, 2'd3, 1'b1, 4'hF); tick();
    chk("t4_valid_b", 32'(bus.valid_out), 32'h8);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF); tick();

    // ready on the wrong channel only
    drive(1'b1, 8'h30, 2'd1, 1'b1, 4'hF); tick();
    drive(1'b1, 8'h31, 2'd2, 1'b1, 4'hD);
    repeat (3) tick();
    bus.ready_in = 4'hF; tick();
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF); tick(); tick();

    // reset mid-packet
    drive(1'b1, 8'h40, 2'd2, 1'b0, 4'hF); tick();
    do_rst();
    drive(1'b1, 8'h41, 2'd0, 1'b1, 4'hF); tick();
    chk("t6_valid", 32'(bus.valid_out), 32'h1);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF); tick();

    // random traffic with sporadic resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_rst();
      end else begin
        drive(1'($urandom_range(0, 99) < 70), 8'($urandom), 2'($urandom),
              1'($urandom_range(0, 2) == 0),
              {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)});
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
